// File: rtl/key_cmd_pkg.sv
// rtl/key_cmd_pkg.sv - key indices, priority order and default timing for key_cmd_gen
package key_cmd_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_ROT   = 3;

    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5000000;
    localparam logic [23:0] DEF_REPEAT_RATE     = 24'd1500000;
    localparam int          DEF_CNT_W           = 24;

    // Lower key index wins: left > right > down > rot.
    function automatic logic [NUM_KEYS-1:0] prio_grant(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] g;
        g = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (req[k]) begin
                g    = '0;
                g[k] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, debouncer, hold counter and press/repeat events
module key_debounce
    import key_cmd_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int          CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic key_event
);

    localparam logic [CNT_W-1:0] HC_MAX  = '1;
    localparam logic [CNT_W-1:0] RD      = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 24'd1);

    logic             sync1;
    logic             s;
    logic             stable_q;
    logic [15:0]      db_cnt;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] rate_cnt;
    logic             press;
    logic             repeat_hit;

    always_comb begin
        press      = stable & ~stable_q;
        repeat_hit = stable & ((hc == RD) | ((hc > RD) & (rate_cnt == RR_LAST)));
        key_event  = press | (REPEAT_EN & repeat_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            s        <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            db_cnt   <= '0;
            hc       <= '0;
            rate_cnt <= '0;
        end else begin
            sync1    <= btn;
            s        <= sync1;
            stable_q <= stable;

            if (s == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                stable <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end

            // hc is 0 on the press cycle, so it counts cycles since press while held.
            if (!stable) begin
                hc       <= '0;
                rate_cnt <= '0;
            end else begin
                if (hc != HC_MAX) hc <= hc + CNT_W'(1);
                if (repeat_hit || hc <= RD) rate_cnt <= '0;
                else                        rate_cnt <= rate_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - pending bits, left/right conflict mask and priority arbiter for move commands
module key_cmd_gen
    import key_cmd_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit          ROT_REPEAT      = 1'b0,
    parameter int          CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rot,
    output logic left,
    output logic right,
    output logic down,
    output logic ro
);

    logic [NUM_KEYS-1:0] btn_vec;
    logic [NUM_KEYS-1:0] stable_vec;
    logic [NUM_KEYS-1:0] event_vec;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] pending_n;
    logic [NUM_KEYS-1:0] grant;
    logic [NUM_KEYS-1:0] cmd;

    assign btn_vec[KEY_LEFT]  = btn_left;
    assign btn_vec[KEY_RIGHT] = btn_right;
    assign btn_vec[KEY_DOWN]  = btn_down;
    assign btn_vec[KEY_ROT]   = btn_rot;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      ((k == KEY_ROT) ? ROT_REPEAT : 1'b1),
            .CNT_W          (CNT_W)
        ) u_key (
            .clk      (clk),
            .rst      (rst),
            .btn      (btn_vec[k]),
            .stable   (stable_vec[k]),
            .key_event(event_vec[k])
        );
    end

    // Masking with stable drops a key's pending bit on release; left+right held together cancel.
    always_comb begin
        grant     = prio_grant(pending);
        pending_n = ((pending & ~grant) | event_vec) & stable_vec;
        if (stable_vec[KEY_LEFT] && stable_vec[KEY_RIGHT]) begin
            pending_n[KEY_LEFT]  = 1'b0;
            pending_n[KEY_RIGHT] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            cmd     <= '0;
        end else begin
            pending <= pending_n;
            cmd     <= grant;
        end
    end

    assign left  = cmd[KEY_LEFT];
    assign right = cmd[KEY_RIGHT];
    assign down  = cmd[KEY_DOWN];
    assign ro    = cmd[KEY_ROT];

endmodule

// File: tb/tb_key_cmd_gen.sv
// tb/tb_key_cmd_gen.sv - directed self-checking bench for key_cmd_gen
module tb_key_cmd_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic btn_down = 1'b0;
    logic btn_rot = 1'b0;
    logic left;
    logic right;
    logic down;
    logic ro;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int multi_hot = 0;
    int pulses[4][$];
    int e0;
    int r0;
    int exp_q[$];

    always #5 clk = ~clk;

    key_cmd_gen #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_RATE    (24'd8),
        .ROT_REPEAT     (1'b0),
        .CNT_W          (24)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_down (btn_down),
        .btn_rot  (btn_rot),
        .left     (left),
        .right    (right),
        .down     (down),
        .ro       (ro)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: edge count at which each output was seen high.
    always @(negedge clk) begin
        if (left)  pulses[0].push_back(cyc);
        if (right) pulses[1].push_back(cyc);
        if (down)  pulses[2].push_back(cyc);
        if (ro)    pulses[3].push_back(cyc);
        if (int'(left) + int'(right) + int'(down) + int'(ro) > 1) multi_hot++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        for (int k = 0; k < 4; k++) pulses[k].delete();
    endtask

    task automatic expect_pulses(input string tag, input int key, input int exp[$]);
        check($sformatf("%s_count", tag), pulses[key].size(), exp.size());
        for (int i = 0; i < exp.size() && i < pulses[key].size(); i++)
            check($sformatf("%s_edge%0d", tag, i), pulses[key][i], exp[i]);
    endtask

    initial begin
        rst = 1'b1;
        tick(3);
        check("reset_out", {28'd0, ro, down, right, left}, 32'd0);
        rst = 1'b0;
        tick(2);
        check("idle_out", {28'd0, ro, down, right, left}, 32'd0);
        clear_pulses();

        // 1: clean left press
        e0 = cyc + 1;
        btn_left = 1'b1; tick(10);
        btn_left = 1'b0; tick(20);
        exp_q = {e0 + 7};
        expect_pulses("t1_left", 0, exp_q);
        for (int k = 1; k < 4; k++) check($sformatf("t1_quiet%0d", k), pulses[k].size(), 0);
        clear_pulses();

        // 2: bounce and sub-threshold glitch, then a just-long-enough pulse
        btn_down = 1'b1; tick(1);
        btn_down = 1'b0; tick(1);
        btn_down = 1'b1; tick(1);
        btn_down = 1'b0; tick(20);
        check("t2_bounce", pulses[2].size(), 0);
        btn_down = 1'b1; tick(3);
        btn_down = 1'b0; tick(20);
        check("t2_glitch3", pulses[2].size(), 0);
        e0 = cyc + 1;
        btn_down = 1'b1; tick(4);
        btn_down = 1'b0; tick(20);
        exp_q = {e0 + 7};
        expect_pulses("t2_accept4", 2, exp_q);
        clear_pulses();

        // 3: right auto-repeat
        e0 = cyc + 1;
        btn_right = 1'b1; tick(60);
        btn_right = 1'b0; tick(25);
        exp_q = {e0 + 7, e0 + 27, e0 + 35, e0 + 43, e0 + 51, e0 + 59};
        expect_pulses("t3_right", 1, exp_q);
        clear_pulses();

        // 4: rotate does not repeat
        e0 = cyc + 1;
        btn_rot = 1'b1; tick(60);
        btn_rot = 1'b0; tick(25);
        exp_q = {e0 + 7};
        expect_pulses("t4_rot", 3, exp_q);
        clear_pulses();

        // 5a: left and down together, left has priority
        e0 = cyc + 1;
        btn_left = 1'b1; btn_down = 1'b1; tick(10);
        btn_left = 1'b0; btn_down = 1'b0; tick(20);
        exp_q = {e0 + 7};
        expect_pulses("t5_left", 0, exp_q);
        exp_q = {e0 + 8};
        expect_pulses("t5_down", 2, exp_q);
        clear_pulses();

        // 5b: left+right conflict, left repeats resume once right is released
        e0 = cyc + 1;
        btn_left = 1'b1; btn_right = 1'b1; tick(30);
        btn_right = 1'b0; tick(20);
        btn_left = 1'b0; tick(25);
        exp_q = {e0 + 43, e0 + 51};
        expect_pulses("t5_conflict_left", 0, exp_q);
        check("t5_conflict_right", pulses[1].size(), 0);
        clear_pulses();

        // 6: reset mid-hold, fresh press afterwards
        e0 = cyc + 1;
        btn_left = 1'b1; tick(30);
        rst = 1'b1; tick(1);
        clear_pulses();
        check("t6_rst_c1", {28'd0, ro, down, right, left}, 32'd0);
        tick(1);
        check("t6_rst_c2", {28'd0, ro, down, right, left}, 32'd0);
        tick(1);
        check("t6_rst_c3", {28'd0, ro, down, right, left}, 32'd0);
        rst = 1'b0;
        r0 = cyc + 1;
        tick(15);
        exp_q = {r0 + 7};
        expect_pulses("t6_fresh_left", 0, exp_q);
        btn_left = 1'b0; tick(20);

        check("one_hot", multi_hot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
